branch_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 30 +++
 rtl/bp_sat_cnt.sv | 30 +++
 rtl/branch_predictor.sv | 171 +++++++++++++++++
 tb/tb_branch_predictor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
// Holds the 2-bit counter encoding and its saturating step.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_INIT = WNT;

  function automatic bht_state_t sat_next(
    input bht_state_t state,
    input logic       taken
  );
    bht_state_t n;
    n = state;
    unique case (state)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = BHT_INIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// One 2-bit saturating history counter.
// Steps toward taken/not-taken when enabled.
module bp_sat_cnt
  import bp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       taken,
  output bht_state_t state
);

  bht_state_t state_q;
  bht_state_t state_d;

  // next counter value on an enabled update
  always_comb begin
    state_d = state_q;
    if (en) state_d = sat_next(state_q, taken);
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BHT_INIT;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with direct-mapped BTB.
// One-cycle lookup, EX-side training, perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  logic [XLEN-1:0]  pred_pc,
  input  logic             flush,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_mispred,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] look_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             unused_pc_lsb;

  assign look_idx = pred_pc[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign look_tag = pred_pc[XLEN-1:IDX_W+2];
  assign upd_tag  = upd_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsb = ^{pred_pc[1:0], upd_pc[1:0]};

  bht_state_t cnt [N];

  for (genvar i = 0; i < N; i++) begin : g_bht
    bp_sat_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (upd_valid && (upd_idx == IDX_W'(i))),
      .taken (upd_taken),
      .state (cnt[i])
    );
  end

  logic             btb_v_q   [N];
  logic [TAG_W-1:0] btb_tag_q [N];
  logic [XLEN-1:0]  btb_tgt_q [N];
  logic             btb_v_d   [N];
  logic [TAG_W-1:0] btb_tag_d [N];
  logic [XLEN-1:0]  btb_tgt_d [N];

  logic             btb_wr;
  assign btb_wr = upd_valid & upd_taken;

  // BTB write on taken resolutions
  always_comb begin
    for (int i = 0; i < N; i++) begin
      btb_v_d[i]   = btb_v_q[i];
      btb_tag_d[i] = btb_tag_q[i];
      btb_tgt_d[i] = btb_tgt_q[i];
    end
    if (btb_wr) begin
      btb_v_d[upd_idx]   = 1'b1;
      btb_tag_d[upd_idx] = upd_tag;
      btb_tgt_d[upd_idx] = upd_target;
    end
  end

  // BTB storage; only valid bits need reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        btb_v_q[i]   <= btb_v_d[i];
        btb_tag_q[i] <= btb_tag_d[i];
        btb_tgt_q[i] <= btb_tgt_d[i];
      end
    end
  end

  logic             same_idx;
  bht_state_t       look_cnt;
  logic             look_v;
  logic [TAG_W-1:0] look_btag;
  logic [XLEN-1:0]  look_tgt;
  logic             look_hit;

  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [XLEN-1:0]  pred_target_q, pred_target_d;

  // lookup with write-through bypass of a same-index update
  always_comb begin
    same_idx  = upd_valid && (upd_idx == look_idx);
    look_cnt  = cnt[look_idx];
    look_v    = btb_v_q[look_idx];
    look_btag = btb_tag_q[look_idx];
    look_tgt  = btb_tgt_q[look_idx];
    if (same_idx) begin
      look_cnt = sat_next(cnt[look_idx], upd_taken);
      if (upd_taken) begin
        look_v    = 1'b1;
        look_btag = upd_tag;
        look_tgt  = upd_target;
      end
    end
    look_hit      = look_cnt[1] & look_v & (look_btag == look_tag);
    pred_valid_d  = pred_req & ~flush;
    pred_taken_d  = pred_valid_d & look_hit;
    pred_target_d = pred_taken_d ? look_tgt : '0;
  end

  // registered prediction outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // saturating perf counters
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid && !(&branch_cnt_q))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (upd_valid && upd_mispred && !(&mispred_cnt_q))
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  // perf counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// A narrow-counter twin checks stats saturation.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        flush;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  logic        s_pred_valid;
  logic        s_pred_taken;
  logic [31:0] s_pred_target;
  logic [3:0]  s_branch_cnt;
  logic [3:0]  s_mispred_cnt;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc), .flush(flush),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predictor #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc), .flush(flush),
    .pred_valid(s_pred_valid), .pred_taken(s_pred_taken),
    .pred_target(s_pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred),
    .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    pred_req    = 1'b0;
    pred_pc     = '0;
    flush       = 1'b0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_taken   = 1'b0;
    upd_target  = '0;
    upd_mispred = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pred_req = 1'b1;
    pred_pc  = pc;
    @(negedge clk);
    idle();
  endtask

  task automatic update(input logic [31:0] pc,
                        input logic t,
                        input logic [31:0] tgt,
                        input logic mis);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = t;
    upd_target  = tgt;
    upd_mispred = mis;
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_valid", 64'(pred_valid), 64'h0);
    chk("rst_bcnt", 64'(branch_cnt), 64'h0);

    lookup(32'h8000_0040);
    chk("cold_valid", 64'(pred_valid), 64'h1);
    chk("cold_taken", 64'(pred_taken), 64'h0);
    chk("cold_target", 64'(pred_target), 64'h0);
    chk("cold_bcnt", 64'(branch_cnt), 64'h0);
    chk("cold_mcnt", 64'(mispred_cnt), 64'h0);

    update(32'h8000_0040, 1'b1, 32'h8000_0100, 1'b0);
    update(32'h8000_0040, 1'b1, 32'h8000_0100, 1'b0);
    lookup(32'h8000_0040);
    chk("trained_taken", 64'(pred_taken), 64'h1);
    chk("trained_target", 64'(pred_target), 64'h8000_0100);

    lookup(32'h9000_0040);
    chk("alias_valid", 64'(pred_valid), 64'h1);
    chk("alias_taken", 64'(pred_taken), 64'h0);
    chk("alias_target", 64'(pred_target), 64'h0);

    update(32'h8000_0040, 1'b0, 32'h0, 1'b0);
    lookup(32'h8000_0040);
    chk("nt1_taken", 64'(pred_taken), 64'h1);
    update(32'h8000_0040, 1'b0, 32'h0, 1'b0);
    lookup(32'h8000_0040);
    chk("nt2_taken", 64'(pred_taken), 64'h0);
    update(32'h8000_0040, 1'b0, 32'h0, 1'b0);
    lookup(32'h8000_0040);
    chk("nt3_taken", 64'(pred_taken), 64'h0);
    update(32'h8000_0040, 1'b0, 32'h0, 1'b0);
    lookup(32'h8000_0040);
    chk("nt4_taken", 64'(pred_taken), 64'h0);
    update(32'h8000_0040, 1'b1, 32'h8000_0100, 1'b0);
    lookup(32'h8000_0040);
    chk("hold00_taken", 64'(pred_taken), 64'h0);

    pred_req   = 1'b1;
    pred_pc    = 32'h8000_0080;
    upd_valid  = 1'b1;
    upd_pc     = 32'h8000_0080;
    upd_taken  = 1'b1;
    upd_target = 32'h8000_0200;
    @(negedge clk);
    idle();
    chk("bypass_valid", 64'(pred_valid), 64'h1);
    chk("bypass_taken", 64'(pred_taken), 64'h1);
    chk("bypass_target", 64'(pred_target), 64'h8000_0200);

    pred_req   = 1'b1;
    pred_pc    = 32'h8000_0044;
    flush      = 1'b1;
    upd_valid  = 1'b1;
    upd_pc     = 32'h8000_0044;
    upd_taken  = 1'b1;
    upd_target = 32'h8000_0300;
    @(negedge clk);
    idle();
    chk("flush_valid", 64'(pred_valid), 64'h0);
    chk("flush_taken", 64'(pred_taken), 64'h0);
    lookup(32'h8000_0044);
    chk("postflush_taken", 64'(pred_taken), 64'h1);
    chk("postflush_target", 64'(pred_target), 64'h8000_0300);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      update(32'h8000_0040, 1'b1, 32'h8000_0100, 1'(i % 2 == 1 && i < 8));
    chk("stats_bcnt10", 64'(branch_cnt), 64'd10);
    chk("stats_mcnt4", 64'(mispred_cnt), 64'd4);
    chk("small_bcnt10", 64'(s_branch_cnt), 64'd10);
    chk("small_mcnt4", 64'(s_mispred_cnt), 64'd4);
    upd_mispred = 1'b1;
    @(negedge clk);
    upd_mispred = 1'b0;
    chk("stray_mispred", 64'(mispred_cnt), 64'd4);
    for (int i = 0; i < 12; i++)
      update(32'h8000_0040, 1'b1, 32'h8000_0100, 1'b1);
    chk("stats_bcnt22", 64'(branch_cnt), 64'd22);
    chk("stats_mcnt16", 64'(mispred_cnt), 64'd16);
    chk("small_bcnt_sat", 64'(s_branch_cnt), 64'hF);
    chk("small_mcnt_sat", 64'(s_mispred_cnt), 64'hF);

    lookup(32'h8000_0040);
    chk("pre_rst_taken", 64'(pred_taken), 64'h1);
    chk("pre_rst_target", 64'(pred_target), 64'h8000_0100);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(pred_valid), 64'h0);
    chk("arst_taken", 64'(pred_taken), 64'h0);
    chk("arst_target", 64'(pred_target), 64'h0);
    chk("arst_bcnt", 64'(branch_cnt), 64'h0);
    chk("arst_mcnt", 64'(mispred_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lookup(32'h8000_0040);
    chk("arst_table_taken", 64'(pred_taken), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
